aclint_timer: RTL
=================

ACLINT_TIMER -- requirements
Module: aclint_timer

Interface
REQ-001 SHALL have parameter N_HARTS, default 1, number of harts served (1..64).
REQ-002 SHALL have parameter TICK_DIV, default 1, CLK cycles per mtime increment (1..65535).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_X  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port w_offset  input  16  byte offset of access within the block.
REQ-006 SHALL have port w_we  input  1  write strobe, one write per asserted cycle.
REQ-007 SHALL have port w_be  input  4  byte-lane write enables for w_wdata.
REQ-008 SHALL have port w_wdata  input  32  write data.
REQ-009 SHALL have port w_rdata  output  32  registered read data.
REQ-010 SHALL have port w_mtip  output  N_HARTS  machine timer interrupt pending, per hart.
REQ-011 SHALL have port w_msip  output  N_HARTS  machine software interrupt pending, per hart.
REQ-012 SHALL have port w_ssip  output  N_HARTS  supervisor software interrupt pending, per hart.
REQ-013 SHALL have port w_mtime  output  64  current mtime value.

Function
REQ-014 SHALL decode: msip[i] at 0x0000+4i (bit0 only, other bits read 0); mtimecmp[i] low/high at 0x4000+8i / 0x4004+8i; ctrl at 0xBFF0 (bit0 RUN, other bits read 0); mtime low/high at 0xBFF8 / 0xBFFC; ssip[i] at 0xC000+4i (bit0 only).
REQ-015 SHALL apply writes only to bytes with w_be set; unselected bytes keep their value; w_be=0 is a no-op.
REQ-016 SHALL ignore writes to unmapped offsets and return 0 on reads of them.
REQ-017 SHALL present w_rdata one cycle after w_offset is sampled, reflecting register contents before any same-cycle write.
REQ-018 SHALL hold a prescaler counting 0..TICK_DIV-1 while RUN=1; tick asserted in the cycle the prescaler equals TICK_DIV-1, after which it wraps to 0.
REQ-019 SHALL increment mtime by 1 on each tick; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-020 SHALL freeze prescaler and mtime while RUN=0; clearing RUN leaves both values unchanged.
REQ-021 SHALL, on a write to either mtime half, load the written bytes, suppress that cycle's increment (write wins) and clear the prescaler to 0.
REQ-022 SHALL treat mtime halves independently: writing one half never carries into or alters the other half.
REQ-023 SHALL register w_mtip[i] = (mtime >= mtimecmp[i]) unsigned 64-bit compare on current register values, i.e. one cycle latency after mtime or mtimecmp changes.
REQ-024 SHALL drive w_msip[i] and w_ssip[i] directly from stored bit0 (visible the cycle after the write).
REQ-025 SHALL drive w_mtime directly from the mtime register.

Reset
REQ-026 SHALL, while RST_X=0 at a clock edge, set mtime=0, prescaler=0, RUN=1, all msip/ssip=0, all mtimecmp=0xFFFF_FFFF_FFFF_FFFF, w_rdata=0, w_mtip=0, ignoring w_we.
REQ-027 SHALL, when reset asserts mid-operation, discard any same-cycle write and resume counting from 0 on the first cycle after RST_X returns high.

Verification
REQ-028 SHALL cover: TICK_DIV=4, reset release, run 40 cycles -> mtime=10, w_mtip=0 (mtimecmp all-ones).
REQ-029 SHALL cover: write mtimecmp0 low=0x20, high=0x0 -> w_mtip[0] rises exactly one cycle after mtime reaches 0x20.
REQ-030 SHALL cover: mtime=0xFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 -> two cycles later mtime=0, w_mtip with mtimecmp=0x10 drops.
REQ-031 SHALL cover: write 0xBFF0 = 0 -> mtime constant for 100 cycles; write 1 -> counting resumes from held value.
REQ-032 SHALL cover: N_HARTS=4, write 0x000C=1 and 0xC008=1 -> w_msip=4'b1000, w_ssip=4'b0100; reads return 1 next cycle.
REQ-033 SHALL cover: mtime write with w_be=4'b0011, wdata=0xAAAA_5555 to 0xBFF8 in tick cycle -> low 16 bits = 0x5555, bits 31:16 unchanged, no increment that cycle.

Source files
------------

// File: rtl/aclint_timer.sv
// aclint_timer: ACLINT machine timer with per-hart mtimecmp/msip/ssip and a prescaled mtime.
module aclint_timer #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [15:0]        w_offset,
  input  logic               w_we,
  input  logic [3:0]         w_be,
  input  logic [31:0]        w_wdata,
  output logic [31:0]        w_rdata,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [N_HARTS-1:0] w_ssip,
  output logic [63:0]        w_mtime
);
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic [63:0]        mtime_q, mtime_d;
  logic [15:0]        presc_q, presc_d;
  logic               run_q, run_d;
  logic [N_HARTS-1:0] msip_q, msip_d, ssip_q, ssip_d, mtip_q, mtip_d;
  logic [63:0]        cmp_q [N_HARTS];
  logic [63:0]        cmp_d [N_HARTS];
  logic [31:0]        rdata_q, rdata_d;
  logic               tick, wr;

  assign wr   = w_we && w_be != 4'b0;
  assign tick = run_q && presc_q == LAST;

  always_comb begin
    run_d   = run_q;
    presc_d = run_q ? (tick ? 16'd0 : presc_q + 16'd1) : presc_q;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    ssip_d  = ssip_q;
    cmp_d   = cmp_q;
    rdata_d = 32'd0;
    if (w_offset == 16'hBFF0) rdata_d = {31'd0, run_q};
    if (w_offset == 16'hBFF8) rdata_d = mtime_q[31:0];
    if (w_offset == 16'hBFFC) rdata_d = mtime_q[63:32];
    for (int i = 0; i < N_HARTS; i++) begin
      mtip_d[i] = mtime_q >= cmp_q[i];
      if (w_offset == 16'(4 * i)) rdata_d = {31'd0, msip_q[i]};
      if (w_offset == 16'(16'hC000 + 4 * i)) rdata_d = {31'd0, ssip_q[i]};
      if (w_offset == 16'(16'h4000 + 8 * i)) rdata_d = cmp_q[i][31:0];
      if (w_offset == 16'(16'h4004 + 8 * i)) rdata_d = cmp_q[i][63:32];
      if (wr && w_be[0] && w_offset == 16'(4 * i)) msip_d[i] = w_wdata[0];
      if (wr && w_be[0] && w_offset == 16'(16'hC000 + 4 * i)) ssip_d[i] = w_wdata[0];
      if (wr && w_offset == 16'(16'h4000 + 8 * i)) cmp_d[i][31:0] = merge(cmp_q[i][31:0], w_wdata, w_be);
      if (wr && w_offset == 16'(16'h4004 + 8 * i)) cmp_d[i][63:32] = merge(cmp_q[i][63:32], w_wdata, w_be);
    end
    if (wr && w_be[0] && w_offset == 16'hBFF0) run_d = w_wdata[0];
    // an mtime write overrides this cycle's tick and restarts the prescaler phase
    if (wr && w_offset == 16'hBFF8) begin
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], w_wdata, w_be)};
      presc_d = 16'd0;
    end
    if (wr && w_offset == 16'hBFFC) begin
      mtime_d = {merge(mtime_q[63:32], w_wdata, w_be), mtime_q[31:0]};
      presc_d = 16'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      mtime_q <= '0;
      presc_q <= '0;
      run_q   <= 1'b1;
      msip_q  <= '0;
      ssip_q  <= '0;
      mtip_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < N_HARTS; i++) cmp_q[i] <= '1;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      run_q   <= run_d;
      msip_q  <= msip_d;
      ssip_q  <= ssip_d;
      mtip_q  <= mtip_d;
      rdata_q <= rdata_d;
      cmp_q   <= cmp_d;
    end
  end

  assign w_rdata = rdata_q;
  assign w_mtip  = mtip_q;
  assign w_msip  = msip_q;
  assign w_ssip  = ssip_q;
  assign w_mtime = mtime_q;
endmodule
